// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the address-width helper for the regfile_sb slice
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_ZERO = 0;
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, registered popcount and reserve-conflict pulse
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = 32,
  parameter int AW = addr_width(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      busy_cnt,
  output logic             rsv_conflict
);
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             rsv_live, conflict_nxt;
  assign rsv_live = rsv_en && rsv_addr != AW'(REG_ZERO);
  assign conflict_nxt = rsv_live && !flush && busy[rsv_addr] && !(wr_en && wr_addr == rsv_addr);
  // A same-edge reserve beats the writeback clear; flush beats both.
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_addr] = 1'b0;
    if (rsv_live) busy_nxt[rsv_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[REG_ZERO] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      busy_cnt <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      busy <= busy_nxt;
      busy_cnt <= cnt_nxt;
      rsv_conflict <= conflict_nxt;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with issue scoreboard; REGFILE_BYPASS_EN forwards same-cycle writeback to reads
module regfile_sb import regfile_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  localparam int AW = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush,
  output logic [AW:0]       busy_cnt,
  output logic              rsv_conflict
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != AW'(REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end
  regfile_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .rsv_en(rsv_en),
    .rsv_addr(rsv_addr),
    .flush(flush),
    .busy(busy),
    .busy_cnt(busy_cnt),
    .rsv_conflict(rsv_conflict)
  );
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          nz;
    assign ra = rd_addr[p*AW +: AW];
    assign nz = ra != AW'(REG_ZERO);
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = nz && wr_en && wr_addr == ra;
    assign rd_data[p*XLEN +: XLEN] = !nz ? '0 : hit ? wr_data : regs[ra];
    assign rd_busy[p] = nz && busy[ra] && !hit;
`else
    assign rd_data[p*XLEN +: XLEN] = nz ? regs[ra] : '0;
    assign rd_busy[p] = nz && busy[ra];
`endif
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (default config or REGFILE_BYPASS_EN)
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic        flush = 1'b0;
  logic [5:0]  busy_cnt;
  logic        rsv_conflict;
  int checks = 0;
  int errors = 0;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(busy_cnt), .rsv_conflict(rsv_conflict)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    #12 rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
        errors++;
        $display("FAIL reset_read x%0d: data=%h busy=%b cnt=%0d, want 0/00/0", a, rd_data, rd_busy, busy_cnt);
      end
    end
  endtask

  task automatic test_rsv_write();
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick();
    idle();
    rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_busy !== 2'b01 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL rsv_x5: busy=%b cnt=%0d, want 01/1", rd_busy, busy_cnt);
    end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL wr_x5: data=%h busy=%b cnt=%0d, want deadbeef/0/0", rd_data[31:0], rd_busy[0], busy_cnt);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
    logic        exp_b;
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'h12; exp_b = 1'b0;
`else
    exp_d = 32'h0; exp_b = 1'b1;
`endif
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
    rd_addr = {5'd7, 5'd5};
    #1;
    checks++;
    if (rd_data[63:32] !== exp_d || rd_busy[1] !== exp_b) begin
      errors++;
      $display("FAIL same_cycle_x7: data=%h busy=%b, want %h/%b", rd_data[63:32], rd_busy[1], exp_d, exp_b);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[63:32] !== 32'h12 || rd_busy[1] !== 1'b0 || busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL after_wr_x7: data=%h busy=%b cnt=%0d, want 12/0/0", rd_data[63:32], rd_busy[1], busy_cnt);
    end
  endtask

  task automatic test_conflict();
    rd_addr = {5'd0, 5'd3};
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    checks++;
    if (rsv_conflict !== 1'b0 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL rsv_x3_first: conflict=%b cnt=%0d, want 0/1", rsv_conflict, busy_cnt);
    end
    tick();
    idle();
    checks++;
    if (rsv_conflict !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL rsv_x3_again: conflict=%b cnt=%0d, want 1/1", rsv_conflict, busy_cnt);
    end
    tick();
    checks++;
    if (rsv_conflict !== 1'b0 || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL conflict_pulse_end: conflict=%b busy=%b, want 0/1", rsv_conflict, rd_busy[0]);
    end
    rsv_en = 1'b1; rsv_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd1 || rsv_conflict !== 1'b0 || rd_data[31:0] !== 32'h33 || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rsv_wr_x3: cnt=%0d conflict=%b data=%h busy=%b, want 1/0/33/1", busy_cnt, rsv_conflict, rd_data[31:0], rd_busy[0]);
    end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL clear_x3: cnt=%0d, want 0", busy_cnt);
    end
  endtask

  task automatic test_flush();
    for (int a = 1; a < 32; a++) begin
      rsv_en = 1'b1; rsv_addr = 5'(a);
      tick();
    end
    idle();
    checks++;
    if (busy_cnt !== 6'd31) begin
      errors++;
      $display("FAIL reserve_all: cnt=%0d, want 31", busy_cnt);
    end
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr = {5'd31, 5'd9};
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rsv_conflict !== 1'b0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush: cnt=%0d conflict=%b busy=%b, want 0/0/00", busy_cnt, rsv_conflict, rd_busy);
    end
    rsv_en = 1'b1; rsv_addr = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd_addr = {5'd0, 5'd0};
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_cnt !== 6'd0) begin
      errors++;
      $display("FAIL x0_write: data=%h busy=%b cnt=%0d, want 0/00/0", rd_data, rd_busy, busy_cnt);
    end
  endtask

  task automatic test_async_reset();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h55;
    tick();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    rsv_addr = 5'd6;
    tick();
    idle();
    rd_addr = {5'd4, 5'd10};
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || rd_data[31:0] !== 32'h55 || rd_busy !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset: cnt=%0d data=%h busy=%b, want 2/55/10", busy_cnt, rd_data[31:0], rd_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rd_data !== 64'h0 || rd_busy !== 2'b00 || rsv_conflict !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cnt=%0d data=%h busy=%b conflict=%b, want 0/0/00/0", busy_cnt, rd_data, rd_busy, rsv_conflict);
    end
    #1 rst_n = 1'b1;
    rsv_en = 1'b1; rsv_addr = 5'd2;
    rd_addr = {5'd2, 5'd6};
    tick();
    idle();
    checks++;
    if (busy_cnt !== 6'd1 || rd_busy !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_rsv: cnt=%0d busy=%b, want 1/10", busy_cnt, rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_rsv_write();
    test_bypass();
    test_conflict();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, 32, data width in bits.
REQ-002 Parameter NREGS, 32, register count (power of 2, >=2); AW = clog2(NREGS).
REQ-003 Parameter NRD, 2, number of read ports (1..4).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  writeback strobe.
REQ-008 wr_addr  in  AW  writeback register index.
REQ-009 wr_data  in  XLEN  writeback data.
REQ-010 rd_addr  in  NRD*AW  packed read indices; port i is bits [i*AW +: AW].
REQ-011 rd_data  out  NRD*XLEN  packed read data, combinational.
REQ-012 rd_busy  out  NRD  per-port pending-write flag, combinational.
REQ-013 rsv_en  in  1  reserve destination at issue.
REQ-014 rsv_addr  in  AW  register index to reserve.
REQ-015 flush  in  1  clear all reservations (pipeline kill).
REQ-016 busy_cnt  out  AW+1  registered count of reserved registers.
REQ-017 rsv_conflict  out  1  registered one-cycle pulse: reserve hit an already-busy register.

Function
REQ-018 Register 0 SHALL read as zero, ignore writes and never become busy.
REQ-019 Write: if wr_en and wr_addr!=0, regs[wr_addr] <= wr_data at the edge; visible on rd_data the cycle after.
REQ-020 Scoreboard: rsv_en with rsv_addr!=0 sets busy[rsv_addr] at the edge; wr_en clears busy[wr_addr] at the edge.
REQ-021 Same-edge rsv and wr to the same index: data is written and busy ends SET (new reservation wins).
REQ-022 flush clears every busy bit at the edge, overrides same-cycle rsv_en; wr_en data is still written.
REQ-023 rd_busy[i] = busy[rd_addr_i] and rd_addr_i!=0, modified per REQ-028.
REQ-024 busy_cnt SHALL equal the popcount of busy after every edge; range 0..NREGS-1, no wrap.
REQ-025 rsv_conflict asserts for exactly the cycle after an edge where rsv_en hit an index already busy (flush absent, wr_en not clearing it that cycle); busy stays set.

Reset
REQ-026 rst_n low SHALL immediately clear all registers to 0, all busy bits, busy_cnt to 0 and rsv_conflict to 0, independent of clk.
REQ-027 Reset mid-operation discards pending reservations; first edge after rst_n rises processes inputs normally.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN: defined -> a read port whose nonzero address matches wr_addr with wr_en high returns wr_data and deasserts rd_busy in the same cycle; undefined -> returns the old stored value and current busy bit.

Structure
REQ-029 Package regfile_pkg SHALL hold XLEN default, REG_ZERO index constant and the clog2-based address-width function.
REQ-030 Busy bits, popcount and conflict logic SHALL live in sub-module regfile_scoreboard; storage and read muxing stay in regfile_sb.

Verification
REQ-031 Reset, then read all 32 indices on both ports -> rd_data 0, rd_busy 0, busy_cnt 0.
REQ-032 rsv x5; next cycle read x5 -> rd_busy 1, busy_cnt 1; wr x5=0xDEADBEEF -> next cycle rd_data 0xDEADBEEF, rd_busy 0, busy_cnt 0.
REQ-033 Same cycle wr x7=0x12 and read x7 -> 0x12, rd_busy 0 with REGFILE_BYPASS_EN; old value without it.
REQ-034 rsv x3 then rsv x3 again -> rsv_conflict 1 for one cycle, busy_cnt stays 1; rsv+wr x3 same edge -> busy_cnt 1, data updated.
REQ-035 Reserve x1..x31, then flush with rsv x9 -> busy_cnt 31 then 0; write x0=0xFFFFFFFF -> reads 0.
REQ-036 Reserve x4, x6, pulse rst_n low between edges -> busy_cnt and registers 0 immediately.
